// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the shared data memory.
// Serves one access at a time: IDLE -> ACCESS (ACC_CYCLES) -> DONE -> IDLE.
module mem_arbiter #(
    parameter int DW         = 256,
    parameter int AW         = 3,
    parameter int ACC_CYCLES = 1
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          rw0,
    input  logic          rw1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_nEnable,
    output logic          mem_rw,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_oe,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = 3;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        state, nextState;
    logic          owner, last, rwLat, grantPort;
    logic [AW-1:0] addrLat;
    logic [DW-1:0] wdataLat;
    logic [CW-1:0] cnt;

    // On a tie the port that did not win last time gets the memory.
    assign grantPort = (req0 && req1) ? ~last : req1;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState   = state;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        done0       = 1'b0;
        done1       = 1'b0;
        mem_nEnable = 1'b1;
        mem_rw      = 1'b1;
        mem_oe      = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) nextState = ACCESS;
            end
            ACCESS: begin
                gnt0        = ~owner;
                gnt1        = owner;
                mem_nEnable = 1'b0;
                mem_rw      = rwLat;
                mem_oe      = ~rwLat;
                if (cnt == '0) nextState = DONE;
            end
            DONE: begin
                gnt0      = ~owner;
                gnt1      = owner;
                done0     = ~owner;
                done1     = owner;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    assign mem_addr  = addrLat;
    assign mem_wdata = wdataLat;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            owner    <= 1'b0;
            last     <= 1'b1;
            rwLat    <= 1'b1;
            addrLat  <= '0;
            wdataLat <= '0;
            cnt      <= '0;
            rdata    <= '0;
        end else begin
            if (state == IDLE && (req0 || req1)) begin
                owner    <= grantPort;
                last     <= grantPort;
                rwLat    <= grantPort ? rw1 : rw0;
                addrLat  <= grantPort ? addr1 : addr0;
                wdataLat <= grantPort ? wdata1 : wdata0;
                cnt      <= CW'(ACC_CYCLES - 1);
            end
            if (state == ACCESS) begin
                if (cnt != '0)  cnt <= cnt - 1'b1;
                else if (rwLat) rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (ACC_CYCLES 1 and 3), directed steps plus
// random traffic checked against a transaction-level timeline/scoreboard model.
module tb_mem_arbiter;
    localparam int DW = 256;
    localparam int AW = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst[2];
    logic          req0[2], req1[2], rw0[2], rw1[2];
    logic [AW-1:0] addr0[2], addr1[2];
    logic [DW-1:0] wdata0[2], wdata1[2];
    logic          gnt0[2], gnt1[2], done0[2], done1[2];
    logic [DW-1:0] rdata[2], mwdata[2], mrdata[2];
    logic [AW-1:0] maddr[2];
    logic          nen[2], mrw[2], moe[2];
    logic [DW-1:0] mem[2][8];
    logic          memClr;

    for (genvar g = 0; g < 2; g++) begin : gInst
        mem_arbiter #(.DW(DW), .AW(AW), .ACC_CYCLES(g == 0 ? 1 : 3)) dut (
            .clk(clk), .Reset(rst[g]),
            .req0(req0[g]), .req1(req1[g]), .rw0(rw0[g]), .rw1(rw1[g]),
            .addr0(addr0[g]), .addr1(addr1[g]), .wdata0(wdata0[g]), .wdata1(wdata1[g]),
            .gnt0(gnt0[g]), .gnt1(gnt1[g]), .done0(done0[g]), .done1(done1[g]),
            .rdata(rdata[g]), .mem_addr(maddr[g]), .mem_nEnable(nen[g]), .mem_rw(mrw[g]),
            .mem_wdata(mwdata[g]), .mem_oe(moe[g]), .mem_rdata(mrdata[g]));
    end

    // Memory models: write while enabled with ReadWrite=0, asynchronous read.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (memClr) begin
                for (int a = 0; a < 8; a++) mem[k][a] <= '0;
            end else if (!nen[k] && !mrw[k]) begin
                mem[k][maddr[k]] <= mwdata[k];
            end
        end
    end
    always_comb begin
        for (int k = 0; k < 2; k++) mrdata[k] = mem[k][maddr[k]];
    end

    int checks = 0, failures = 0, cur = 0;
    // Reference model: remaining busy cycles of the current transaction plus scoreboard.
    int rem, owner, lastP;
    logic          oRw;
    logic [AW-1:0] oAddr;
    logic [DW-1:0] oData, refRdata;
    logic [DW-1:0] refMem[2][8];

    function automatic int accOf(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [DW-1:0] rnd();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk1(input string tag, input logic o, input logic e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s inst=%0d observed=%0h expected=%0h", tag, cur, o, e);
        end
    endtask

    task automatic chkV(input string tag, input logic [DW-1:0] o, input logic [DW-1:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s inst=%0d observed=%0h expected=%0h", tag, cur, o, e);
        end
    endtask

    task automatic chkI(input string tag, input int o, input int e);
        checks++;
        assert (o == e) else begin
            failures++;
            $error("FAIL %s inst=%0d observed=%0d expected=%0d", tag, cur, o, e);
        end
    endtask

    task automatic setPort(input int p, input logic r, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin req0[cur] = r; rw0[cur] = w; addr0[cur] = a; wdata0[cur] = d; end
        else        begin req1[cur] = r; rw1[cur] = w; addr1[cur] = a; wdata1[cur] = d; end
    endtask

    // Advance one clock, update the model from the inputs present at the edge, check outputs.
    task automatic step();
        logic r0, r1, sRw0, sRw1, inAcc, inDone;
        logic [AW-1:0] sA0, sA1;
        logic [DW-1:0] sD0, sD1;
        r0 = req0[cur]; r1 = req1[cur]; sRw0 = rw0[cur]; sRw1 = rw1[cur];
        sA0 = addr0[cur]; sA1 = addr1[cur]; sD0 = wdata0[cur]; sD1 = wdata1[cur];
        @(posedge clk);
        if (rem > 0) rem--;
        else if (r0 || r1) begin
            owner = (r0 && r1) ? 1 - lastP : (r1 ? 1 : 0);
            lastP = owner;
            oRw   = owner ? sRw1 : sRw0;
            oAddr = owner ? sA1 : sA0;
            oData = owner ? sD1 : sD0;
            rem   = accOf(cur) + 1;
        end
        if (rem == 1) begin
            if (oRw) refRdata = refMem[cur][oAddr];
            else     refMem[cur][oAddr] = oData;
        end
        #1;
        inAcc  = rem > 1;
        inDone = rem == 1;
        chk1("gnt0", gnt0[cur], rem > 0 && owner == 0);
        chk1("gnt1", gnt1[cur], rem > 0 && owner == 1);
        chk1("done0", done0[cur], inDone && owner == 0);
        chk1("done1", done1[cur], inDone && owner == 1);
        chk1("mem_nEnable", nen[cur], !inAcc);
        chk1("mem_oe", moe[cur], inAcc && !oRw);
        chkV("rdata", rdata[cur], refRdata);
        if (inAcc) begin
            chkI("mem_addr", int'(maddr[cur]), int'(oAddr));
            chk1("mem_rw", mrw[cur], oRw);
            if (!oRw) chkV("mem_wdata", mwdata[cur], oData);
        end
    endtask

    task automatic rstCheck();
        rst[cur] = 1'b1;
        #1;
        chk1("rst_gnt0", gnt0[cur], 1'b0);
        chk1("rst_gnt1", gnt1[cur], 1'b0);
        chk1("rst_done0", done0[cur], 1'b0);
        chk1("rst_done1", done1[cur], 1'b0);
        chkV("rst_rdata", rdata[cur], '0);
        chkI("rst_mem_addr", int'(maddr[cur]), 0);
        chk1("rst_nEnable", nen[cur], 1'b1);
        chk1("rst_mem_rw", mrw[cur], 1'b1);
        chk1("rst_mem_oe", moe[cur], 1'b0);
        chkV("rst_mem_wdata", mwdata[cur], '0);
        rem = 0; lastP = 1; refRdata = '0;
        @(posedge clk);
        #1;
        rst[cur] = 1'b0;
    endtask

    task automatic xfer(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int lat, output int low, output logic [DW-1:0] rd);
        setPort(p, 1'b1, w, a, d);
        lat = -1; low = 0; rd = '0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (!nen[cur]) low++;
            if ((p == 0 ? done0[cur] : done1[cur]) === 1'b1) begin
                lat = i; rd = rdata[cur];
                break;
            end
        end
        setPort(p, 1'b0, w, a, d);
        step();
    endtask

    task automatic randomRun(input int n);
        for (int i = 0; i < n; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!(p == 0 ? req0[cur] : req1[cur]))
                    setPort(p, $urandom_range(0, 2) == 0, 1'($urandom), AW'($urandom), rnd());
            end
            step();
            if (done0[cur]) req0[cur] = 1'b0;
            if (done1[cur]) req1[cur] = 1'b0;
        end
        req0[cur] = 1'b0; req1[cur] = 1'b0;
        repeat (6) step();
    endtask

    initial begin
        int lat, low, nd, cnt;
        int order[4];
        logic [DW-1:0] rd;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; req0[k] = 1'b0; req1[k] = 1'b0; rw0[k] = 1'b1; rw1[k] = 1'b1;
            addr0[k] = '0; addr1[k] = '0; wdata0[k] = '0; wdata1[k] = '0;
            for (int a = 0; a < 8; a++) refMem[k][a] = '0;
        end
        memClr = 1'b1;
        @(posedge clk);
        #1;
        memClr = 1'b0;

        // ---- instance 0: ACC_CYCLES = 1 ----
        cur = 0;
        rstCheck();
        xfer(0, 1'b0, 3'd0, DW'(42), lat, low, rd);
        chkI("wr_latency", lat, 2);
        chkI("wr_nEnable_cycles", low, 1);
        xfer(1, 1'b1, 3'd0, '0, lat, low, rd);
        chkV("rd_data", rd, DW'(42));
        chkI("rd_latency", lat, 2);

        rstCheck();
        setPort(0, 1'b1, 1'b1, 3'd1, '0);
        setPort(1, 1'b1, 1'b1, 3'd2, '0);
        nd = 0;
        for (int i = 0; i < 40 && nd < 4; i++) begin
            step();
            if (done0[cur]) begin order[nd] = 0; nd++; end
            else if (done1[cur]) begin order[nd] = 1; nd++; end
        end
        req0[cur] = 1'b0; req1[cur] = 1'b0;
        step();
        chkI("rr_count", nd, 4);
        for (int i = 0; i < 4; i++) chkI("rr_order", order[i], i % 2);

        setPort(0, 1'b1, 1'b0, 3'd3, DW'(77));
        step();
        req0[cur] = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done0[cur]) cnt++;
        end
        chkI("drop_done_count", cnt, 1);
        chk1("drop_idle_gnt0", gnt0[cur], 1'b0);
        chk1("drop_idle_nEnable", nen[cur], 1'b1);

        randomRun(300);

        // ---- instance 1: ACC_CYCLES = 3 ----
        cur = 1;
        rstCheck();
        xfer(0, 1'b0, 3'd7, DW'(203), lat, low, rd);
        chkI("wr3_latency", lat, 4);
        chkI("wr3_nEnable_cycles", low, 3);
        xfer(1, 1'b1, 3'd7, '0, lat, low, rd);
        chkV("rd3_data", rd, DW'(203));
        chkI("rd3_latency", lat, 4);
        chkI("rd3_nEnable_cycles", low, 3);

        setPort(1, 1'b1, 1'b1, 3'd5, '0);
        step();
        step();
        #2;
        rst[cur] = 1'b1;
        #1;
        chk1("midrst_nEnable", nen[cur], 1'b1);
        chk1("midrst_oe", moe[cur], 1'b0);
        chk1("midrst_gnt0", gnt0[cur], 1'b0);
        chk1("midrst_gnt1", gnt1[cur], 1'b0);
        chk1("midrst_done1", done1[cur], 1'b0);
        rem = 0; lastP = 1; refRdata = '0;
        req1[cur] = 1'b0;
        @(posedge clk);
        #1;
        chk1("midrst_held_done1", done1[cur], 1'b0);
        rst[cur] = 1'b0;
        setPort(0, 1'b1, 1'b1, 3'd7, '0);
        setPort(1, 1'b1, 1'b1, 3'd5, '0);
        step();
        chk1("postrst_tie_gnt0", gnt0[cur], 1'b1);
        for (int i = 0; i < 10 && !done0[cur]; i++) step();
        req0[cur] = 1'b0;
        for (int i = 0; i < 10 && !done1[cur]; i++) step();
        req1[cur] = 1'b0;
        step();

        randomRun(300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
